reg_write_arbiter: RTL and testbench

Round-robin arbiter sharing the single write port of the 32-bit register bank (a set of `flopr_param`-style reset registers with per-register load) among several requesters, e.g. writeback, load unit, debug port. Each cycle it picks at most one requester, acknowledges it combinationally, and drives a registered write command (`wr_en`/`wr_addr`/`wr_data`) to the bank one cycle later. An optional lock lets one requester hold the port for back-to-back writes.

---
 rtl/reg_write_arbiter.sv | 79 +++++++
 tb/tb_reg_write_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin arbiter for the single write port of the register bank.
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   req, lock           per-requester request valid and hold-port-after-transfer
//   addr, data          packed per-requester target address and write data
//   gnt                 one-hot combinational acknowledge
//   wr_en/addr/data     registered write command to the bank, one cycle after transfer
//   busy                registered, high while a requester holds the port
module reg_write_arbiter #(
    parameter int WIDTH = 32,
    parameter int NREQ = 4,
    parameter int AW = 3,
    parameter bit ZERO_PROTECT = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       lock,
    input  logic [NREQ*AW-1:0]    addr,
    input  logic [NREQ*WIDTH-1:0] data,
    output logic [NREQ-1:0]       gnt,
    output logic                  wr_en,
    output logic [AW-1:0]         wr_addr,
    output logic [WIDTH-1:0]      wr_data,
    output logic                  busy
);
    localparam int PW = $clog2(NREQ);
    typedef enum logic {IDLE, LOCKED} state_t;
    state_t state, state_n;
    logic [PW-1:0] ptr, owner, pick, win, idx;
    logic hit, xfer;
    logic [AW-1:0] a [NREQ];
    logic [WIDTH-1:0] d [NREQ];
    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign a[i] = addr[i*AW +: AW];
        assign d[i] = data[i*WIDTH +: WIDTH];
    end
    // first asserted request searching from ptr upwards, wrapping at NREQ
    always_comb begin
        hit = 1'b0;
        pick = '0;
        idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = PW'((int'(ptr) + k) % NREQ);
            if (!hit && req[idx]) begin
                hit = 1'b1;
                pick = idx;
            end
        end
    end
    assign win = (state == LOCKED) ? owner : pick;
    assign xfer = !rst && ((state == LOCKED) ? req[owner] : hit);
    assign gnt = xfer ? NREQ'(1) << win : '0;
    // a locked owner that drops req or lock releases the port
    assign state_n = (state == IDLE) ? ((xfer && lock[win]) ? LOCKED : IDLE)
                                     : ((req[owner] && lock[owner]) ? LOCKED : IDLE);
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr <= '0;
            owner <= '0;
            wr_en <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            busy <= 1'b0;
        end else begin
            state <= state_n;
            busy <= (state_n == LOCKED);
            wr_en <= xfer && !(ZERO_PROTECT && a[win] == '0);
            if (xfer) begin
                ptr <= (win == PW'(NREQ-1)) ? '0 : win + 1'b1;
                wr_addr <= a[win];
                wr_data <= d[win];
            end
            if (state == IDLE && xfer)
                owner <= win;
        end
    end
endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter: directed and randomized checks of reg_write_arbiter against a behavioural model.
module tb_reg_write_arbiter;
    localparam int WIDTH = 32, NREQ = 4, AW = 3;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NREQ-1:0] req = '0, lock = '0;
    logic [NREQ*AW-1:0] addr = '0;
    logic [NREQ*WIDTH-1:0] data = '0;
    logic [NREQ-1:0] gnt, gnt0;
    logic wr_en, wr_en0, busy, busy0;
    logic [AW-1:0] wr_addr, wr_addr0;
    logic [WIDTH-1:0] wr_data, wr_data0;
    int errors = 0, checks = 0;

    int m_ptr = 0, m_owner = 0;
    bit m_locked = 0, m_en = 0, m_en0 = 0;
    logic [AW-1:0] m_addr = '0;
    logic [WIDTH-1:0] m_data = '0;

    reg_write_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .AW(AW), .ZERO_PROTECT(1'b1)) dut (
        .clk(clk), .rst(rst), .req(req), .lock(lock), .addr(addr), .data(data),
        .gnt(gnt), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy));
    reg_write_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .AW(AW), .ZERO_PROTECT(1'b0)) dut0 (
        .clk(clk), .rst(rst), .req(req), .lock(lock), .addr(addr), .data(data),
        .gnt(gnt0), .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0), .busy(busy0));

    always #5 clk = ~clk;

    // winning requester index for the current inputs, -1 if none
    function automatic int pick();
        if (rst) return -1;
        if (m_locked) return req[m_owner] ? m_owner : -1;
        for (int k = 0; k < NREQ; k++)
            if (req[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] exp_gnt();
        int w = pick();
        return (w < 0) ? '0 : NREQ'(1) << w;
    endfunction

    task automatic model_edge();
        int w = pick();
        if (rst) begin
            m_ptr = 0; m_owner = 0; m_locked = 0; m_en = 0; m_en0 = 0; m_addr = '0; m_data = '0;
        end else if (w < 0) begin
            m_en = 0; m_en0 = 0;
            m_locked = 0;
        end else begin
            m_addr = addr[w*AW +: AW];
            m_data = data[w*WIDTH +: WIDTH];
            m_en0 = 1;
            m_en = (m_addr != 0);
            m_ptr = (w + 1) % NREQ;
            if (m_locked) m_locked = lock[w];
            else if (lock[w]) begin m_locked = 1; m_owner = w; end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_port(input int i, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        addr[i*AW +: AW] = a;
        data[i*WIDTH +: WIDTH] = d;
    endtask

    task automatic do_reset();
        rst = 1; req = '0; lock = '0;
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1; req = 4'b1111;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++; if (gnt !== 4'b0000 || gnt0 !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b/%b expected 0000", gnt, gnt0); end
            tick();
            checks++; if ({wr_en, busy} !== 2'b00) begin errors++; $display("FAIL reset_flags: wr_en=%b busy=%b expected 0 0", wr_en, busy); end
            checks++; if (wr_addr !== '0 || wr_data !== '0) begin errors++; $display("FAIL reset_cmd: addr=%0d data=%0h expected 0 0", wr_addr, wr_data); end
        end
        rst = 0;
        #1;
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL reset_first_gnt: got %b expected 0001", gnt); end
        req = '0;
        tick();
    endtask

    task automatic test_single();
        do_reset();
        set_port(0, 3'd3, 32'd400);
        req = 4'b0001;
        #1;
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt: got %b expected 0001", gnt); end
        tick();
        req = '0;
        checks++; if (wr_en !== 1'b1 || wr_addr !== 3'd3 || wr_data !== 32'd400) begin errors++; $display("FAIL single_cmd: en=%b addr=%0d data=%0d expected 1 3 400", wr_en, wr_addr, wr_data); end
        tick();
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL single_idle: wr_en=%b expected 0", wr_en); end
    endtask

    task automatic test_fairness();
        do_reset();
        for (int i = 0; i < NREQ; i++) set_port(i, AW'(i + 1), 32'd100 + i);
        req = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++; if (gnt !== NREQ'(1) << (c % NREQ)) begin errors++; $display("FAIL fair_gnt%0d: got %b expected %b", c, gnt, NREQ'(1) << (c % NREQ)); end
            tick();
            checks++; if (wr_en !== 1'b1 || wr_data !== 32'd100 + c % NREQ) begin errors++; $display("FAIL fair_data%0d: en=%b data=%0d expected 1 %0d", c, wr_en, wr_data, 100 + c % NREQ); end
        end
        req = '0;
        tick();
    endtask

    task automatic test_lock();
        logic [NREQ-1:0] eg [4] = '{4'b0100, 4'b0100, 4'b0100, 4'b0001};
        bit eb [4] = '{0, 1, 1, 0};
        do_reset();
        set_port(1, 3'd5, 32'd11);
        set_port(2, 3'd6, 32'd22);
        set_port(0, 3'd2, 32'd33);
        req = 4'b0010;
        tick();
        req = 4'b0101; lock = 4'b0100;
        for (int c = 0; c < 4; c++) begin
            if (c == 2) lock = '0;
            if (c == 3) req = 4'b0001;
            #1;
            checks++; if (gnt !== eg[c] || busy !== eb[c]) begin errors++; $display("FAIL lock_c%0d: gnt=%b busy=%b expected %b %b", c, gnt, busy, eg[c], eb[c]); end
            tick();
        end
        set_port(3, 3'd7, 32'd44);
        req = 4'b1000; lock = 4'b1000;
        #1;
        checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL lock_take3: got %b expected 1000", gnt); end
        tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL lock_busy3: got %b expected 1", busy); end
        req = 4'b0001;
        #1;
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL lock_abandon_gnt: got %b expected 0000", gnt); end
        tick();
        lock = '0;
        #1;
        checks++; if (busy !== 1'b0 || gnt !== 4'b0001) begin errors++; $display("FAIL lock_abandon_exit: busy=%b gnt=%b expected 0 0001", busy, gnt); end
        req = '0;
        tick();
    endtask

    task automatic test_zero_protect();
        do_reset();
        set_port(1, 3'd0, 32'hDEADBEEF);
        req = 4'b0010;
        #1;
        checks++; if (gnt !== 4'b0010 || gnt0 !== 4'b0010) begin errors++; $display("FAIL zp_gnt: got %b/%b expected 0010", gnt, gnt0); end
        tick();
        req = '0;
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL zp_blocked: wr_en=%b expected 0", wr_en); end
        checks++; if (wr_en0 !== 1'b1 || wr_addr0 !== 3'd0 || wr_data0 !== 32'hDEADBEEF) begin errors++; $display("FAIL zp_off: en=%b addr=%0d data=%0h expected 1 0 deadbeef", wr_en0, wr_addr0, wr_data0); end
        #1;
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL zp_consumed: gnt=%b expected 0000", gnt); end
        tick();
    endtask

    task automatic test_reset_mid_lock();
        do_reset();
        set_port(3, 3'd4, 32'd55);
        req = 4'b1000; lock = 4'b1000;
        tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rml_locked: busy=%b expected 1", busy); end
        rst = 1; req = 4'b1001; lock = 4'b1001;
        #1;
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rml_gnt_rst: got %b expected 0000", gnt); end
        tick();
        rst = 0; lock = '0;
        #1;
        checks++; if (busy !== 1'b0 || wr_en !== 1'b0) begin errors++; $display("FAIL rml_cleared: busy=%b wr_en=%b expected 0 0", busy, wr_en); end
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL rml_next_gnt: got %b expected 0001", gnt); end
        req = '0;
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 500; n++) begin
            rst = ($urandom_range(0, 59) == 0);
            req = NREQ'($urandom);
            lock = ($urandom_range(0, 2) == 0) ? NREQ'($urandom) : '0;
            for (int i = 0; i < NREQ; i++)
                set_port(i, ($urandom_range(0, 3) == 0) ? '0 : AW'($urandom), $urandom);
            #1;
            checks++; if (gnt !== exp_gnt() || gnt0 !== exp_gnt()) begin errors++; $display("FAIL rnd_gnt%0d: got %b/%b expected %b", n, gnt, gnt0, exp_gnt()); end
            tick();
            checks++; if (wr_en !== m_en || wr_en0 !== m_en0) begin errors++; $display("FAIL rnd_en%0d: got %b/%b expected %b/%b", n, wr_en, wr_en0, m_en, m_en0); end
            checks++; if (busy !== m_locked || busy0 !== m_locked) begin errors++; $display("FAIL rnd_busy%0d: got %b/%b expected %b", n, busy, busy0, m_locked); end
            if (m_en0) begin
                checks++; if (wr_addr0 !== m_addr || wr_data0 !== m_data) begin errors++; $display("FAIL rnd_cmd0_%0d: addr=%0d data=%0h expected %0d %0h", n, wr_addr0, wr_data0, m_addr, m_data); end
            end
            if (m_en) begin
                checks++; if (wr_addr !== m_addr || wr_data !== m_data) begin errors++; $display("FAIL rnd_cmd_%0d: addr=%0d data=%0h expected %0d %0h", n, wr_addr, wr_data, m_addr, m_data); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_lock();
        test_zero_protect();
        test_reset_mid_lock();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
